// File: rtl/ahbl_excl_monitor.sv
`timescale 1ns/1ps
// Global exclusive monitor between an AHBL arbiter and a shared slave: one reservation per
// master, combinational address-phase verdict, failed store-exclusives become IDLE downstream.
module ahbl_excl_monitor #(
  parameter int N_MASTERS    = 2,
  parameter int W_ADDR       = 32,
  parameter int W_DATA       = 32,
  parameter int GRANULE_BITS = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              src_hready,
  output logic              src_hready_resp,
  output logic              src_hresp,
  input  logic [W_ADDR-1:0] src_haddr,
  input  logic              src_hwrite,
  input  logic [1:0]        src_htrans,
  input  logic [2:0]        src_hsize,
  input  logic [W_DATA-1:0] src_hwdata,
  output logic [W_DATA-1:0] src_hrdata,
  input  logic              src_hexcl,
  input  logic [7:0]        src_hmaster,
  output logic              src_hexokay,
  output logic              dst_hready,
  input  logic              dst_hready_resp,
  input  logic              dst_hresp,
  output logic [W_ADDR-1:0] dst_haddr,
  output logic              dst_hwrite,
  output logic [1:0]        dst_htrans,
  output logic [2:0]        dst_hsize,
  output logic [W_DATA-1:0] dst_hwdata,
  input  logic [W_DATA-1:0] dst_hrdata
);

  localparam int         W_GRAN = W_ADDR - GRANULE_BITS;
  localparam logic [7:0] NM     = 8'(N_MASTERS);

  logic                 aphase, id_ok, match, verdict;
  logic                 is_ldx, is_stx, is_wr, stx_ok, stx_fail;
  logic [W_GRAN-1:0]    gran;
  logic [N_MASTERS-1:0] self_hit, gran_hit;
  logic [N_MASTERS-1:0] res_valid_q, res_valid_d;
  logic [W_GRAN-1:0]    res_gran_q [N_MASTERS];
  logic [W_GRAN-1:0]    res_gran_d [N_MASTERS];
  logic                 excl_q, ok_q;

  assign dst_hready      = src_hready;
  assign dst_haddr       = src_haddr;
  assign dst_hwrite      = src_hwrite;
  assign dst_hsize       = src_hsize;
  assign dst_hwdata      = src_hwdata;
  assign src_hready_resp = dst_hready_resp;
  assign src_hresp       = dst_hresp;
  assign src_hrdata      = dst_hrdata;

  assign aphase = src_hready & src_htrans[1];
  assign id_ok  = (src_hmaster < NM);
  assign gran   = src_haddr[W_ADDR-1:GRANULE_BITS];

  always_comb begin
    for (int m = 0; m < N_MASTERS; m++) begin
      self_hit[m] = (src_hmaster == 8'(m));
      gran_hit[m] = (res_gran_q[m] == gran);
    end
  end

  // self_hit can only be set for in-range IDs, so out-of-range masters never match
  assign match    = id_ok & (|(self_hit & gran_hit & res_valid_q));
  assign is_ldx   = aphase & src_hexcl & ~src_hwrite;
  assign is_stx   = aphase & src_hexcl & src_hwrite;
  assign is_wr    = aphase & ~src_hexcl & src_hwrite;
  assign stx_ok   = is_stx & match;
  assign stx_fail = is_stx & ~match;
  assign verdict  = (is_ldx & id_ok) | stx_ok;

  assign dst_htrans  = stx_fail ? 2'b00 : src_htrans;
  assign src_hexokay = excl_q & ok_q;

  always_comb begin
    res_valid_d = res_valid_q;
    for (int m = 0; m < N_MASTERS; m++) begin
      res_gran_d[m] = res_gran_q[m];
      if (is_ldx && self_hit[m]) begin
        res_valid_d[m] = 1'b1;
        res_gran_d[m]  = gran;
      end else if ((is_wr || stx_ok) && gran_hit[m]) begin
        res_valid_d[m] = 1'b0;
      end else if (stx_fail && self_hit[m]) begin
        res_valid_d[m] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= '0;
      for (int m = 0; m < N_MASTERS; m++) res_gran_q[m] <= '0;
      excl_q <= 1'b0;
      ok_q   <= 1'b0;
    end else begin
      res_valid_q <= res_valid_d;
      for (int m = 0; m < N_MASTERS; m++) res_gran_q[m] <= res_gran_d[m];
      if (src_hready) begin
        excl_q <= aphase & src_hexcl;
        ok_q   <= verdict;
      end
    end
  end

endmodule

// File: tb/tb_ahbl_excl_monitor.sv
`timescale 1ns/1ps
// Scoreboard bench: directed transfers push expected address/data-phase results, a negedge
// monitor pops and compares; a small wait-state-capable memory slave sits downstream.
module tb_ahbl_excl_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        src_hready, src_hready_resp, src_hresp;
  logic [31:0] src_haddr, src_hwdata, src_hrdata;
  logic        src_hwrite, src_hexcl, src_hexokay;
  logic [1:0]  src_htrans;
  logic [2:0]  src_hsize;
  logic [7:0]  src_hmaster;
  logic        dst_hready, dst_hready_resp, dst_hresp, dst_hwrite;
  logic [31:0] dst_haddr, dst_hwdata, dst_hrdata;
  logic [1:0]  dst_htrans;
  logic [2:0]  dst_hsize;

  always #5 clk = ~clk;

  ahbl_excl_monitor #(.N_MASTERS(2), .W_ADDR(32), .W_DATA(32), .GRANULE_BITS(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .src_hready(src_hready), .src_hready_resp(src_hready_resp), .src_hresp(src_hresp),
    .src_haddr(src_haddr), .src_hwrite(src_hwrite), .src_htrans(src_htrans),
    .src_hsize(src_hsize), .src_hwdata(src_hwdata), .src_hrdata(src_hrdata),
    .src_hexcl(src_hexcl), .src_hmaster(src_hmaster), .src_hexokay(src_hexokay),
    .dst_hready(dst_hready), .dst_hready_resp(dst_hready_resp), .dst_hresp(dst_hresp),
    .dst_haddr(dst_haddr), .dst_hwrite(dst_hwrite), .dst_htrans(dst_htrans),
    .dst_hsize(dst_hsize), .dst_hwdata(dst_hwdata), .dst_hrdata(dst_hrdata)
  );

  // single-slave system: the bus HREADY is the slave's HREADYOUT
  assign src_hready = src_hready_resp;

  // downstream memory slave with programmable wait states
  logic [31:0] mem [256];
  logic        d_vld, d_wr;
  logic [7:0]  d_idx;
  int          wait_cnt, wait_cfg;

  assign dst_hready_resp = !(d_vld && wait_cnt != 0);
  assign dst_hresp       = 1'b0;
  assign dst_hrdata      = d_vld ? mem[d_idx] : 32'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_vld    <= 1'b0;
      d_wr     <= 1'b0;
      d_idx    <= 8'h0;
      wait_cnt <= 0;
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    end else if (dst_hready) begin
      if (d_vld && d_wr) mem[d_idx] <= dst_hwdata;
      d_vld    <= dst_htrans[1];
      d_wr     <= dst_hwrite;
      d_idx    <= dst_haddr[9:2];
      wait_cnt <= wait_cfg;
    end else if (wait_cnt != 0) begin
      wait_cnt <= wait_cnt - 1;
    end
  end

  typedef struct {
    string       nm;
    logic [1:0]  htrans;
    logic        okay;
    bit          chk_rd;
    logic [31:0] rdata;
    int          waits;
  } exp_t;

  exp_t        aq[$];
  exp_t        dq[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] pend_wd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor: address-phase htrans, data-phase hexokay/rdata/wait count
  bit   dph_active = 1'b0;
  int   waits_seen = 0;
  exp_t me;
  always @(negedge clk) begin
    if (!rst_n) begin
      dph_active = 1'b0;
      waits_seen = 0;
      aq.delete();
      dq.delete();
    end else if (src_hready) begin
      if (dph_active) begin
        if (dq.size() == 0) chk("dph_unexpected", 32'd1, 32'd0);
        else begin
          me = dq.pop_front();
          chk({me.nm, "_hexokay"}, 32'(src_hexokay), 32'(me.okay));
          chk({me.nm, "_waits"}, 32'(waits_seen), 32'(me.waits));
          if (me.chk_rd) chk({me.nm, "_rdata"}, src_hrdata, me.rdata);
        end
      end
      waits_seen = 0;
      dph_active = src_htrans[1];
      if (src_htrans[1]) begin
        if (aq.size() == 0) chk("aph_unexpected", 32'd1, 32'd0);
        else begin
          me = aq.pop_front();
          chk({me.nm, "_htrans"}, 32'(dst_htrans), 32'(me.htrans));
        end
      end
    end else if (dph_active) begin
      waits_seen++;
      if (dq.size() != 0) chk({dq[0].nm, "_hexokay_wait"}, 32'(src_hexokay), 32'(dq[0].okay));
    end
  end

  task automatic wait_accept(input string nm);
    int n = 0;
    forever begin
      @(negedge clk);
      if (src_hready) break;
      n++;
      if (n > 20) begin
        chk({nm, "_timeout"}, 32'd1, 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input string nm, input int mst, input logic [31:0] addr,
                       input bit wr, input bit ex, input logic [31:0] wd,
                       input logic [1:0] eht, input bit eok, input bit chk_rd,
                       input logic [31:0] erd, input int w);
    exp_t e;
    e = '{nm, eht, eok, chk_rd, erd, w};
    aq.push_back(e);
    dq.push_back(e);
    src_hmaster = 8'(mst);
    src_haddr   = addr;
    src_hwrite  = wr;
    src_hexcl   = ex;
    src_htrans  = 2'b10;
    src_hsize   = 3'b010;
    src_hwdata  = pend_wd;
    wait_cfg    = w;
    wait_accept(nm);
    pend_wd = wd;
  endtask

  task automatic idle(input int n);
    src_htrans = 2'b00;
    src_hexcl  = 1'b0;
    src_hwrite = 1'b0;
    src_hwdata = pend_wd;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    src_haddr = 32'h0; src_hwrite = 1'b0; src_hexcl = 1'b0; src_htrans = 2'b00;
    src_hsize = 3'b010; src_hwdata = 32'h0; src_hmaster = 8'h0;
    pend_wd = 32'h0; wait_cfg = 0;
    #1;
    chk("reset_hexokay", 32'(src_hexokay), 32'd0);
    chk("reset_hready_resp", 32'(src_hready_resp), 32'd1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // no reservation out of reset
    issue("r_stx",    0, 32'h100, 1, 1, 32'hDEAD_0000, 2'b00, 0, 0, 32'h0, 0);
    issue("r_wr",     0, 32'h100, 1, 0, 32'hA5A5_0001, 2'b10, 0, 0, 32'h0, 0);
    // LDX then STX in same granule, then the reservation is gone
    issue("t1_ldx",   0, 32'h100, 0, 1, 32'h0,         2'b10, 1, 1, 32'hA5A5_0001, 0);
    issue("t1_stx",   0, 32'h104, 1, 1, 32'h0000_0011, 2'b10, 1, 0, 32'h0, 0);
    issue("t1_stx2",  0, 32'h100, 1, 1, 32'h0000_0022, 2'b00, 0, 0, 32'h0, 0);
    issue("t1_rd104", 1, 32'h104, 0, 0, 32'h0,         2'b10, 0, 1, 32'h0000_0011, 0);
    issue("t1_rd100", 1, 32'h100, 0, 0, 32'h0,         2'b10, 0, 1, 32'hA5A5_0001, 0);
    // another master's plain write kills the reservation
    issue("t2_ldx",   0, 32'h100, 0, 1, 32'h0,         2'b10, 1, 0, 32'h0, 0);
    issue("t2_wr",    1, 32'h100, 1, 0, 32'h0000_0033, 2'b10, 0, 0, 32'h0, 0);
    issue("t2_stx",   0, 32'h100, 1, 1, 32'h0000_0044, 2'b00, 0, 0, 32'h0, 0);
    issue("t2_rd",    1, 32'h100, 0, 0, 32'h0,         2'b10, 0, 1, 32'h0000_0033, 0);
    // successful STX clears every reservation on the granule
    issue("t3_ldx0",  0, 32'h100, 0, 1, 32'h0,         2'b10, 1, 1, 32'h0000_0033, 0);
    issue("t3_ldx1",  1, 32'h100, 0, 1, 32'h0,         2'b10, 1, 1, 32'h0000_0033, 0);
    issue("t3_stx1",  1, 32'h100, 1, 1, 32'h0000_0055, 2'b10, 1, 0, 32'h0, 0);
    issue("t3_stx0",  0, 32'h100, 1, 1, 32'h0000_0066, 2'b00, 0, 0, 32'h0, 0);
    issue("t3_stx1b", 1, 32'h100, 1, 1, 32'h0000_0067, 2'b00, 0, 0, 32'h0, 0);
    issue("t3_rd",    0, 32'h100, 0, 0, 32'h0,         2'b10, 0, 1, 32'h0000_0055, 0);
    // STX to another granule fails and drops the requester's reservation
    issue("t4_ldx",   0, 32'h100, 0, 1, 32'h0,         2'b10, 1, 0, 32'h0, 0);
    issue("t4_stx",   0, 32'h108, 1, 1, 32'h0000_0077, 2'b00, 0, 0, 32'h0, 0);
    issue("t4_retry", 0, 32'h100, 1, 1, 32'h0000_0088, 2'b00, 0, 0, 32'h0, 0);
    issue("t4_rd108", 1, 32'h108, 0, 0, 32'h0,         2'b10, 0, 1, 32'h0, 0);
    issue("t4_rd100", 1, 32'h100, 0, 0, 32'h0,         2'b10, 0, 1, 32'h0000_0055, 0);
    // out-of-range master: no reservation, but its plain write still clears others
    issue("t5_ldx",   5, 32'h100, 0, 1, 32'h0,         2'b10, 0, 0, 32'h0, 0);
    issue("t5_stx",   5, 32'h100, 1, 1, 32'h0000_00EE, 2'b00, 0, 0, 32'h0, 0);
    issue("t5_ldx0",  0, 32'h180, 0, 1, 32'h0,         2'b10, 1, 1, 32'h0, 0);
    issue("t5_wr5",   5, 32'h180, 1, 0, 32'h0000_0099, 2'b10, 0, 0, 32'h0, 0);
    issue("t5_stx0",  0, 32'h180, 1, 1, 32'h0000_00AA, 2'b00, 0, 0, 32'h0, 0);
    issue("t5_rd",    1, 32'h180, 0, 0, 32'h0,         2'b10, 0, 1, 32'h0000_0099, 0);
    // successful STX with three slave wait states
    issue("t6_ldx",   0, 32'h100, 0, 1, 32'h0,         2'b10, 1, 1, 32'h0000_0055, 0);
    issue("t6_stx",   0, 32'h100, 1, 1, 32'h0000_00AB, 2'b10, 1, 0, 32'h0, 3);
    issue("t6_rd",    1, 32'h100, 0, 0, 32'h0,         2'b10, 0, 1, 32'h0000_00AB, 0);
    idle(2);

    // reset in the middle of a waited successful STX
    issue("t7_ldx0",  0, 32'h100, 0, 1, 32'h0,         2'b10, 1, 0, 32'h0, 0);
    issue("t7_ldx1",  1, 32'h200, 0, 1, 32'h0,         2'b10, 1, 0, 32'h0, 0);
    issue("t7_stx",   0, 32'h100, 1, 1, 32'h0000_00CD, 2'b10, 1, 0, 32'h0, 3);
    src_htrans = 2'b00;
    src_hexcl  = 1'b0;
    src_hwdata = pend_wd;
    @(posedge clk);
    #2;
    chk("t7_hexokay_before_rst", 32'(src_hexokay), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t7_hexokay_rst", 32'(src_hexokay), 32'd0);
    chk("t7_htrans_rst", 32'(dst_htrans), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue("t7_stx1",  1, 32'h200, 1, 1, 32'h0000_0001, 2'b00, 0, 0, 32'h0, 0);
    issue("t7_stx0",  0, 32'h100, 1, 1, 32'h0000_0002, 2'b00, 0, 0, 32'h0, 0);
    idle(4);

    chk("queues_empty", 32'(aq.size() + dq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahbl_excl_monitor.md
Name: ahbl_excl_monitor

Overview:
- Global exclusive-access monitor between an N:1 AHBL arbiter's slave-side port and a shared memory slave.
- Tracks one load-exclusive reservation per master (identified by hmaster) and decides pass/fail for each store-exclusive.
- Suppresses failed stores toward the slave and returns hexokay to the arbiter.
- All other AHBL traffic passes through unchanged, with no added latency.

Parameters:
- N_MASTERS, 2, number of tracked masters; valid hmaster IDs are 0..N_MASTERS-1.
- W_ADDR, 32, address width.
- W_DATA, 32, data width.
- GRANULE_BITS, 3, log2 of reservation granule in bytes; addresses compare on haddr[W_ADDR-1:GRANULE_BITS].

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- src_hready  in  1  upstream HREADY (address-phase qualifier)
- src_hready_resp  out  1  upstream HREADYOUT
- src_hresp  out  1  upstream HRESP
- src_haddr  in  W_ADDR  upstream address
- src_hwrite  in  1  upstream write
- src_htrans  in  2  upstream HTRANS
- src_hsize  in  3  upstream HSIZE
- src_hwdata  in  W_DATA  upstream write data
- src_hrdata  out  W_DATA  upstream read data
- src_hexcl  in  1  exclusive-access flag, address phase
- src_hmaster  in  8  master ID, address phase
- src_hexokay  out  1  exclusive-access okay, data phase
- dst_hready  out  1  downstream HREADY
- dst_hready_resp  in  1  slave HREADYOUT
- dst_hresp  in  1  slave HRESP
- dst_haddr  out  W_ADDR  downstream address
- dst_hwrite  out  1  downstream write
- dst_htrans  out  2  downstream HTRANS
- dst_hsize  out  3  downstream HSIZE
- dst_hwdata  out  W_DATA  downstream write data
- dst_hrdata  in  W_DATA  slave read data

Behaviour:
- Passthrough, combinational:
  - dst_hready = src_hready; dst_haddr/hwrite/hsize/hwdata = src_*.
  - src_hready_resp = dst_hready_resp; src_hresp = dst_hresp; src_hrdata = dst_hrdata.
- Address phase accepted (aphase) when src_hready & src_htrans[1].
- State per master m: res_valid[m], res_gran[m] (W_ADDR-GRANULE_BITS bits). Reset: all res_valid = 0.
- Lookup is combinational in the address phase:
  - id_ok = src_hmaster < N_MASTERS.
  - match = id_ok & res_valid[hmaster] & (res_gran[hmaster] == granule(src_haddr)).
- Classification at aphase:
  - LDX (hexcl & !hwrite): if id_ok, res_valid[hmaster] <= 1 and res_gran[hmaster] <= granule; the prior reservation is replaced. Verdict ok = id_ok.
  - STX (hexcl & hwrite): ok = match.
    - If ok: clear res_valid for every master (including self) whose res_gran equals granule.
    - If fail: dst_htrans forced to 2'b00 in that same cycle, so the slave sees IDLE and nothing is written. Reservations are unchanged, except the requester's own reservation, which is cleared.
  - Plain write (!hexcl & hwrite): clear res_valid of every master whose res_gran equals granule.
  - Plain read: no state change.
- dst_htrans = src_htrans except for a failed STX as above.
- Data-phase tracking: at every cycle with src_hready high:
  - excl_d <= aphase & src_hexcl
  - ok_d <= verdict
  - Both reset to 0.
- src_hexokay = excl_d & ok_d. Reset value 0.
- Only ID-matching granule comparisons affect state. Unlisted hmaster IDs can still clear others via plain write or successful STX.
- Failed STX data phase: the slave, having seen IDLE, responds zero-wait OKAY. Upstream sees hready_resp=1, hresp=0, hexokay=0 in the next cycle.
- State updates commit at aphase, not at data-phase completion. A later slave error (dst_hresp) does not roll back reservations.
- Back-to-back aphases each evaluate against state already updated by the previous aphase (address order = commit order).
- No aphase when src_hready low: no state change; excl_d/ok_d hold.
- Async reset mid-transfer clears all reservations, excl_d and ok_d immediately.

Test Plan:
- M0 LDX 0x100, then M0 STX 0x104 (same 8B granule) -> STX dst_htrans=10, src_hexokay=1 in its data phase; res_valid[0]=0 afterwards.
- M0 LDX 0x100, M1 plain write 0x100, M0 STX 0x100 -> STX dst_htrans=00 (suppressed), src_hexokay=0, memory unchanged.
- M0 LDX 0x100, M1 LDX 0x100, M1 STX 0x100 succeeds, M0 STX 0x100 -> second STX fails; both reservations cleared.
- M0 LDX 0x100 then M0 STX 0x108 (other granule) -> fail, hexokay=0; M0 reservation cleared, so retry STX 0x100 also fails.
- hmaster=5 with N_MASTERS=2: LDX -> hexokay=0 and no reservation set; following STX -> suppressed, hexokay=0.
- Slave inserts 3 wait states on a successful STX data phase -> src_hready_resp low 3 cycles; src_hexokay held 1 through completion. Assert rst_n mid-wait -> src_hexokay=0 immediately and all reservations invalid.
